// File: rtl/calc_engine.sv
// calc_engine: keypad-driven integer calculator core.
//   Builds WIDTH-bit operands from hex digit events, runs ADD/SUB/MUL in one
//   cycle and a restoring divide in WIDTH cycles, supports chained operators,
//   and scans the shown value across DIGITS hex digits.
// Ports:
//   i_sys_clock, i_sys_reset (async, active-high)
//   i_calc_clear/equal/digit_valid/op_valid : one-cycle event pulses
//   i_calc_digit[3:0], i_calc_op[1:0]       : event payloads
//   o_calc_busy, o_calc_value, o_calc_neg, o_calc_overflow, o_calc_err
//   o_calc_dig[3:0], o_calc_sel[DIGITS-1:0] : multiplexed display
module calc_engine #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = WIDTH / 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              i_sys_clock,
  input  logic              i_sys_reset,
  input  logic              i_calc_clear,
  input  logic              i_calc_equal,
  input  logic              i_calc_digit_valid,
  input  logic [3:0]        i_calc_digit,
  input  logic              i_calc_op_valid,
  input  logic [1:0]        i_calc_op,
  output logic              o_calc_busy,
  output logic [WIDTH-1:0]  o_calc_value,
  output logic              o_calc_neg,
  output logic              o_calc_overflow,
  output logic              o_calc_err,
  output logic [3:0]        o_calc_dig,
  output logic [DIGITS-1:0] o_calc_sel
);
  localparam logic [2:0] S_ENTRY_A = 3'd0, S_ENTRY_B = 3'd1, S_EXEC = 3'd2,
                         S_DIV_RUN = 3'd3, S_RESULT = 3'd4, S_ERROR = 3'd5;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10;
  localparam int NW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d, acc_q, acc_d, rem_q, rem_d;
  logic [1:0]       pend_q, pend_d, nxt_q, nxt_d;
  logic             chain_q, chain_d, fresh_q, fresh_d;
  logic             neg_q, neg_d, ovf_q, ovf_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    scan_q, scan_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [IW-1:0]    idx_q, idx_d;

  // Event priority: clear > equal > op > digit.
  logic ev_eq, ev_op, ev_dig;
  assign ev_eq  = i_calc_equal & ~i_calc_clear;
  assign ev_op  = i_calc_op_valid & ~i_calc_equal & ~i_calc_clear;
  assign ev_dig = i_calc_digit_valid & ~i_calc_op_valid & ~i_calc_equal & ~i_calc_clear;

  logic [WIDTH-1:0]   b, entry, res;
  logic [WIDTH:0]     sum, trial, diff;
  logic [2*WIDTH-1:0] prod;
  logic               q_bit, done, res_neg, res_ovf;

  // fresh_q: no digit typed since the operator; value_q may still be showing
  // the previous chained result, but the logical entry is zero.
  assign b     = fresh_q ? '0 : value_q;
  assign entry = b;
  assign sum   = {1'b0, acc_q} + {1'b0, b};
  assign prod  = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, b};
  // Restoring divide: dividend shifts out of acc_q, quotient shifts into it.
  assign trial = {rem_q, acc_q[WIDTH-1]};
  assign diff  = trial - {1'b0, value_q};
  assign q_bit = trial >= {1'b0, value_q};

  always_comb begin
    state_d = state_q; value_d = value_q; acc_d = acc_q; rem_d = rem_q;
    pend_d = pend_q; nxt_d = nxt_q; chain_d = chain_q; fresh_d = fresh_q;
    neg_d = neg_q; ovf_d = ovf_q; cnt_d = cnt_q;
    res = '0; res_neg = 1'b0; res_ovf = 1'b0; done = 1'b0;
    if (i_calc_clear) begin
      state_d = S_ENTRY_A; value_d = '0; acc_d = '0; rem_d = '0;
      pend_d = '0; nxt_d = '0; chain_d = 1'b0; fresh_d = 1'b0;
      neg_d = 1'b0; ovf_d = 1'b0; cnt_d = '0;
    end else begin
      case (state_q)
        S_ENTRY_A, S_ENTRY_B: begin
          if (ev_eq && state_q == S_ENTRY_B) begin
            chain_d = 1'b0; state_d = S_EXEC;
          end else if (ev_op) begin
            ovf_d = 1'b0;
            if (state_q == S_ENTRY_A) begin
              acc_d = value_q; pend_d = i_calc_op; value_d = '0;
              fresh_d = 1'b1; state_d = S_ENTRY_B;
            end else if (fresh_q) begin
              pend_d = i_calc_op;
            end else begin
              nxt_d = i_calc_op; chain_d = 1'b1; state_d = S_EXEC;
            end
          end else if (ev_dig) begin
            if (entry[WIDTH-1:WIDTH-4] != 4'd0) ovf_d = 1'b1;
            else begin
              value_d = {entry[WIDTH-5:0], i_calc_digit}; fresh_d = 1'b0;
            end
          end
        end
        S_EXEC: begin
          case (pend_q)
            OP_ADD: begin res = sum[WIDTH-1:0]; res_ovf = sum[WIDTH]; done = 1'b1; end
            OP_SUB: begin
              res_neg = acc_q < b;
              res = res_neg ? b - acc_q : acc_q - b;
              done = 1'b1;
            end
            OP_MUL: begin
              res = prod[WIDTH-1:0]; res_ovf = |prod[2*WIDTH-1:WIDTH]; done = 1'b1;
            end
            default: begin
              if (b == '0) state_d = S_ERROR;
              else begin rem_d = '0; cnt_d = '0; state_d = S_DIV_RUN; end
            end
          endcase
        end
        S_DIV_RUN: begin
          rem_d = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_d = {acc_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == NW'(WIDTH - 1)) begin
            res = {acc_q[WIDTH-2:0], q_bit}; done = 1'b1;
          end
        end
        S_RESULT: begin
          if (ev_op) begin
            // A negative or overflowed result is not a valid left operand.
            if (!neg_q && !ovf_q) begin
              acc_d = value_q; pend_d = i_calc_op; value_d = '0;
              fresh_d = 1'b1; state_d = S_ENTRY_B;
            end
          end else if (ev_dig) begin
            neg_d = 1'b0; ovf_d = 1'b0; fresh_d = 1'b0;
            value_d = {{(WIDTH-4){1'b0}}, i_calc_digit}; state_d = S_ENTRY_A;
          end
        end
        default: ;  // S_ERROR: only clear leaves
      endcase
      if (done) begin
        value_d = res; neg_d = res_neg; ovf_d = res_ovf;
        if (chain_d) begin
          // Result stays displayed; fresh_q makes it logically zero.
          acc_d = res; pend_d = nxt_q; fresh_d = 1'b1; chain_d = 1'b0;
          state_d = S_ENTRY_B;
        end else begin
          state_d = S_RESULT;
        end
      end
    end
  end

  // Display scan runs regardless of state and clear.
  always_comb begin
    scan_d = scan_q + 1'b1; sel_d = sel_q; idx_d = idx_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = {sel_q[DIGITS-2:0], sel_q[DIGITS-1]};
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      state_q <= S_ENTRY_A; value_q <= '0; acc_q <= '0; rem_q <= '0;
      pend_q <= '0; nxt_q <= '0; chain_q <= 1'b0; fresh_q <= 1'b0;
      neg_q <= 1'b0; ovf_q <= 1'b0; cnt_q <= '0;
      scan_q <= '0; sel_q <= DIGITS'(1); idx_q <= '0;
    end else begin
      state_q <= state_d; value_q <= value_d; acc_q <= acc_d; rem_q <= rem_d;
      pend_q <= pend_d; nxt_q <= nxt_d; chain_q <= chain_d; fresh_q <= fresh_d;
      neg_q <= neg_d; ovf_q <= ovf_d; cnt_q <= cnt_d;
      scan_q <= scan_d; sel_q <= sel_d; idx_q <= idx_d;
    end
  end

  assign o_calc_busy     = (state_q == S_EXEC) || (state_q == S_DIV_RUN);
  assign o_calc_value    = value_q;
  assign o_calc_neg      = neg_q;
  assign o_calc_overflow = ovf_q;
  assign o_calc_err      = (state_q == S_ERROR);
  assign o_calc_sel      = sel_q;
  assign o_calc_dig      = o_calc_err ? 4'hE : value_q[int'(idx_q)*4 +: 4];
endmodule

// File: tb/tb_calc_engine.sv
module tb_calc_engine;
  localparam int WIDTH = 8;
  localparam int DIGITS = 2;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic clr = 0, eq = 0, dv = 0, ov = 0;
  logic [3:0] dig = 0;
  logic [1:0] op = 0;
  logic busy, neg, ovf, err;
  logic [WIDTH-1:0] val;
  logic [3:0] odig;
  logic [DIGITS-1:0] sel;

  calc_engine #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .i_sys_clock(clk), .i_sys_reset(rst), .i_calc_clear(clr), .i_calc_equal(eq),
    .i_calc_digit_valid(dv), .i_calc_digit(dig), .i_calc_op_valid(ov), .i_calc_op(op),
    .o_calc_busy(busy), .o_calc_value(val), .o_calc_neg(neg), .o_calc_overflow(ovf),
    .o_calc_err(err), .o_calc_dig(odig), .o_calc_sel(sel));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] keys;   // right-justified ASCII; last key is '='
    logic [WIDTH-1:0] val;
    bit neg, ovf, err;
    int busy;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // '!' clear, '&' ADD plus digit 9 in the same cycle.
  task automatic press(input byte c);
    @(negedge clk);
    if (c == "!") clr = 1;
    else if (c == "=") eq = 1;
    else if (c == "+") begin ov = 1; op = 2'd0; end
    else if (c == "-") begin ov = 1; op = 2'd1; end
    else if (c == "*") begin ov = 1; op = 2'd2; end
    else if (c == "/") begin ov = 1; op = 2'd3; end
    else if (c == "&") begin ov = 1; op = 2'd0; dv = 1; dig = 4'h9; end
    else if (c >= "0" && c <= "9") begin dv = 1; dig = 4'(c - 8'd48); end
    else if (c >= "A" && c <= "F") begin dv = 1; dig = 4'(c - 8'd55); end
    @(negedge clk);
    clr = 0; eq = 0; ov = 0; dv = 0;
  endtask

  task automatic press_str(input logic [63:0] keys);
    for (int i = 7; i >= 0; i--) begin
      byte c;
      c = keys[i*8 +: 8];
      if (c != 8'd0) press(c);
    end
  endtask

  // Starts at the first busy cycle; returns at the first idle sample.
  task automatic count_busy(output int cyc);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    vec_t e;
    press("!");
    press_str(v.keys);        // ends with '=' driven
    sb.push_back(v);
    count_busy(cyc);
    e = sb.pop_front();
    check({"busy_cycles ", string'(v.keys)}, cyc, e.busy);
    check({"value ", string'(v.keys)}, val, e.val);
    check({"neg ", string'(v.keys)}, neg, e.neg);
    check({"overflow ", string'(v.keys)}, ovf, e.ovf);
    check({"err ", string'(v.keys)}, err, e.err);
  endtask

  task automatic wait_sel(input logic [DIGITS-1:0] target);
    for (int i = 0; i < 20; i++) begin
      if (sel == target) break;
      @(negedge clk);
    end
    check("sel_reached", sel, target);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{"12+34=",  8'h46, 0, 0, 0, 1};
    vecs[1]  = '{"5-9=",    8'h04, 1, 0, 0, 1};
    vecs[2]  = '{"FF*2=",   8'hFE, 0, 1, 0, 1};
    vecs[3]  = '{"C8/7=",   8'h1C, 0, 0, 0, 9};
    vecs[4]  = '{"5/0=",    8'h00, 0, 0, 1, 1};
    vecs[5]  = '{"3+4+5=",  8'h0C, 0, 0, 0, 1};
    vecs[6]  = '{"FF+1=",   8'h00, 0, 1, 0, 1};
    vecs[7]  = '{"20-20=",  8'h00, 0, 0, 0, 1};
    vecs[8]  = '{"FF/1=",   8'hFF, 0, 0, 0, 9};
    vecs[9]  = '{"7/9=",    8'h00, 0, 0, 0, 9};
    vecs[10] = '{"10*10=",  8'h00, 0, 1, 0, 1};
    vecs[11] = '{"F*F=",    8'hE1, 0, 0, 0, 1};
    vecs[12] = '{"+5=",     8'h05, 0, 0, 0, 1};
    vecs[13] = '{"3-+5=",   8'h08, 0, 0, 0, 1};
    vecs[14] = '{"A0/3=",   8'h35, 0, 0, 0, 9};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_value", val, 0); check("rst_busy", busy, 0); check("rst_neg", neg, 0);
    check("rst_ovf", ovf, 0); check("rst_err", err, 0); check("rst_sel", sel, 1);
    check("rst_dig", odig, 0);
    rst = 0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Display of 0x46: digit 0 shows 6, digit 1 shows 4, then wrap
    run_vec(vecs[0]);
    wait_sel(2'b01); check("disp_lo", odig, 4'h6);
    wait_sel(2'b10); check("disp_hi", odig, 4'h4);
    for (int i = 0; i < SCAN_DIV; i++) begin
      if (sel != 2'b10) break;
      @(negedge clk);
    end
    check("disp_wrap", sel, 2'b01);

    // Negative result: op ignored, clear resets
    run_vec(vecs[1]);
    press("+");
    @(negedge clk);
    check("neg_op_ignored_val", val, 8'h04); check("neg_op_ignored_neg", neg, 1);
    press("!");
    check("neg_clr_val", val, 0); check("neg_clr_neg", neg, 0);

    // Entry overflow, cleared by the next op
    press_str("123");
    check("entry_ovf_val", val, 8'h12); check("entry_ovf_flag", ovf, 1);
    press("+");
    check("entry_ovf_cleared", ovf, 0);

    // Division aborted by clear on the 4th busy cycle
    press("!");
    press_str("C8/7=");
    repeat (2) @(negedge clk);
    check("div_inflight", busy, 1);
    press("!");
    check("div_abort_val", val, 0); check("div_abort_busy", busy, 0);
    repeat (12) @(negedge clk);
    check("div_discarded", val, 0);

    // Divide by zero
    press("!");
    press_str("5/0=");
    @(negedge clk);
    check("dz_err", err, 1); check("dz_busy", busy, 0);
    wait_sel(2'b01); check("dz_dig0", odig, 4'hE);
    wait_sel(2'b10); check("dz_dig1", odig, 4'hE);
    press_str("3=");
    check("dz_ignore_err", err, 1); check("dz_ignore_val", val, 0);
    press("!");
    check("dz_clr_err", err, 0);
    press("5");
    check("dz_entry_a", val, 8'h05);

    // Chain intermediate result
    press("!");
    press_str("3+4+");
    @(negedge clk);
    check("chain_mid", val, 8'h07); check("chain_mid_busy", busy, 0);
    press("5");
    check("chain_new_digit", val, 8'h05);

    // Same-cycle op and digit: op taken, digit dropped
    press("!");
    press_str("3&");
    check("op_dig_val", val, 0);
    press_str("4=");
    count_busy(cyc);
    check("op_dig_result", val, 8'h07);

    // Reset in mid-division
    press("!");
    press_str("C8/7=");
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_busy", busy, 0); check("mid_rst_val", val, 0);
    check("mid_rst_sel", sel, 1);
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    check("mid_rst_stays", val, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
